// File: rtl/nrzi_rx_decoder.sv
// NRZI receive decoder: sync hunt, bit unstuffing and optional byte assembly.
// Optional byte assembler is enabled by defining NRZI_RX_BYTE_EN.
module nrzi_rx_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_en,
    input  logic       in,
    output logic       out,
    output logic       out_valid,
    output logic       sync_found,
    output logic       stuff_err,
    output logic [7:0] byte_out,
    output logic       byte_valid
);

    typedef enum logic {HUNT, DATA} state_t;

    state_t      state, state_nx;
    logic        prev_line;
    logic [7:0]  sync_sh, sync_sh_nx;
    logic [2:0]  ones_cnt, ones_nx;
    logic [7:0]  sync_cand;
    logic        d;
    logic        out_nx, valid_nx, sync_nx, err_nx;
    logic        clr_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            prev_line  <= 1'b1;
            sync_sh    <= '1;
            ones_cnt   <= '0;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            sync_found <= 1'b0;
            stuff_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            sync_sh    <= sync_sh_nx;
            ones_cnt   <= ones_nx;
            out        <= out_nx;
            out_valid  <= valid_nx;
            sync_found <= sync_nx;
            stuff_err  <= err_nx;
            if (bit_en)
                prev_line <= in;
        end
    end

    always_comb begin
        d          = (in == prev_line);
        sync_cand  = {sync_sh[6:0], d};
        state_nx   = state;
        sync_sh_nx = sync_sh;
        ones_nx    = ones_cnt;
        out_nx     = out;
        valid_nx   = 1'b0;
        sync_nx    = 1'b0;
        err_nx     = 1'b0;
        clr_byte   = 1'b0;
        if (bit_en) begin
            case (state)
                HUNT: begin
                    sync_sh_nx = sync_cand;
                    if (sync_cand == 8'b0000_0001) begin
                        sync_nx  = 1'b1;
                        state_nx = DATA;
                        ones_nx  = 3'd1;
                        clr_byte = 1'b1;
                    end
                end
                DATA: begin
                    if (ones_cnt < 3'd6) begin
                        out_nx   = d;
                        valid_nx = 1'b1;
                        ones_nx  = d ? ones_cnt + 3'd1 : 3'd0;
                    end else if (!d) begin
                        // Stuffed zero after six ones: dropped silently
                        ones_nx = 3'd0;
                    end else begin
                        err_nx     = 1'b1;
                        state_nx   = HUNT;
                        sync_sh_nx = '1;
                        ones_nx    = 3'd0;
                        clr_byte   = 1'b1;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

`ifdef NRZI_RX_BYTE_EN
    logic [2:0] bit_cnt;
    logic [7:0] byte_sh;

    // LSB-first: each new bit enters at the top and shifts down
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= '0;
            byte_sh    <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (clr_byte) begin
                bit_cnt <= '0;
                byte_sh <= '0;
            end else if (valid_nx) begin
                byte_sh <= {out_nx, byte_sh[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_out   <= {out_nx, byte_sh[7:1]};
                    byte_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic byte_unused;
    assign byte_unused = clr_byte;
    assign byte_out    = '0;
    assign byte_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Directed self-checking bench for nrzi_rx_decoder (sync, bytes, unstuff, abort, gaps, reset).
module tb_nrzi_rx_decoder;

`ifdef NRZI_RX_BYTE_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bit_en = 1'b0;
    logic       in = 1'b1;
    logic       out, out_valid, sync_found, stuff_err, byte_valid;
    logic [7:0] byte_out;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic        line = 1'b1;

    nrzi_rx_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .bit_en     (bit_en),
        .in         (in),
        .out        (out),
        .out_valid  (out_valid),
        .sync_found (sync_found),
        .stuff_err  (stuff_err),
        .byte_out   (byte_out),
        .byte_valid (byte_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_line(input logic lvl);
        @(negedge clk);
        bit_en = 1'b1;
        in     = lvl;
        line   = lvl;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
    endtask

    task automatic send_dec(input logic dbit);
        send_line(dbit ? line : ~line);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            bit_en = 1'b0;
            in     = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("gap_pulses", {out_valid, sync_found, stuff_err, byte_valid}, 4'b0000);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check("rst_outputs", {out, out_valid, sync_found, stuff_err, byte_valid, byte_out}, '0);
        #1 reset = 1'b0;
        bit_en = 1'b0;
        in     = 1'b1;
        line   = 1'b1;
    endtask

    task automatic do_sync();
        for (int unsigned i = 0; i < 8; i++) begin
            send_dec(i == 7);
            check("sync_ov", out_valid, 1'b0);
            check("sync_pulse", sync_found, i == 7);
        end
    endtask

    task automatic run_byte(input int unsigned gap);
        logic [7:0] pat;
        pat = 8'hA5;
        for (int unsigned i = 0; i < 8; i++) begin
            send_dec(pat[i]);
            check("byte_ov", out_valid, 1'b1);
            check("byte_bit", out, pat[i]);
            check("byte_bv", byte_valid, BYTE_EN && (i == 7));
            check("byte_err", stuff_err, 1'b0);
            if (i == 7)
                check("byte_val", byte_out, BYTE_EN ? 8'hA5 : 8'h00);
            if (i < 7)
                idle(gap);
        end
    endtask

    initial begin
        logic [7:0] sync_line;
        int unsigned nsync, nvalid;

        // Power-on reset
        #3 check("por_outputs", {out, out_valid, sync_found, stuff_err, byte_valid, byte_out}, '0);
        #4 reset = 1'b0;

        // Sync on absolute line levels 0,1,0,1,0,1,0,0
        sync_line = 8'b0010_1010;
        nsync = 0; nvalid = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            send_line(sync_line[i]);
            nsync  += sync_found;
            nvalid += out_valid;
            check("sync30_pulse", sync_found, i == 7);
        end
        check("sync30_count", nsync, 1);
        check("sync30_ov", nvalid, 0);

        // Byte A5 right after sync
        run_byte(0);

        // Unstuff: five ones, stuffed zero dropped, then counter restarts from zero
        do_reset();
        do_sync();
        for (int unsigned i = 0; i < 6; i++) begin
            send_dec(i < 5);
            check("unstuff_ov", out_valid, i < 5);
            if (i < 5) check("unstuff_bit", out, 1'b1);
            check("unstuff_err", stuff_err, 1'b0);
        end
        for (int unsigned i = 0; i < 6; i++) begin
            send_dec(1'b1);
            check("after_stuff_ov", out_valid, 1'b1);
            check("after_stuff_err", stuff_err, 1'b0);
        end
        send_dec(1'b1);
        check("seventh_one_err", stuff_err, 1'b1);
        check("seventh_one_ov", out_valid, 1'b0);

        // Abort: six ones after sync
        do_reset();
        do_sync();
        nvalid = 0;
        for (int unsigned i = 0; i < 6; i++) begin
            send_dec(1'b1);
            nvalid += out_valid;
            check("abort_err", stuff_err, i == 5);
            check("abort_bv", byte_valid, 1'b0);
        end
        check("abort_ov_count", nvalid, 5);
        for (int unsigned i = 0; i < 4; i++) begin
            send_dec(i[0]);
            check("hunt_after_abort_ov", out_valid, 1'b0);
        end
        do_sync();
        send_dec(1'b0);
        check("resync_ov", out_valid, 1'b1);
        check("resync_bit", out, 1'b0);

        // Gaps: same byte with three idle cycles between bits
        do_reset();
        do_sync();
        idle(3);
        run_byte(3);
        idle(3);

        // Mid-frame asynchronous reset, then hunting resumes
        do_reset();
        do_sync();
        send_dec(1'b1);
        send_dec(1'b1);
        check("pre_rst_ov", {out_valid, out}, 2'b11);
        do_reset();
        for (int unsigned i = 0; i < 6; i++) begin
            send_dec(1'b1);
            check("post_rst_hunt_ov", out_valid, 1'b0);
            check("post_rst_sync", sync_found, 1'b0);
        end
        do_sync();
        send_dec(1'b1);
        check("post_rst_data_ov", out_valid, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nrzi_rx_decoder.md
NRZI_RX_DECODER -- requirements
Module: nrzi_rx_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 SHALL have port bit_en, input, 1 bit: qualifies in as a valid line sample on this edge.
REQ-004 SHALL have port in, input, 1 bit: NRZI line level; a toggle encodes 0, no toggle encodes 1.
REQ-005 SHALL have port out, output, 1 bit: decoded, unstuffed data bit.
REQ-006 SHALL have port out_valid, output, 1 bit: one-cycle pulse qualifying out.
REQ-007 SHALL have port sync_found, output, 1 bit: one-cycle pulse on sync detection.
REQ-008 SHALL have port stuff_err, output, 1 bit: one-cycle pulse on bit-stuff violation (frame abort).
REQ-009 SHALL have port byte_out, output, 8 bits: last assembled data byte.
REQ-010 SHALL have port byte_valid, output, 1 bit: one-cycle pulse qualifying byte_out.

Function
REQ-011 SHALL register all outputs; the response to a sample appears after the edge that takes it (1-cycle latency).
REQ-012 SHALL hold prev_line (reset 1) and decode d = 1 when in == prev_line, else 0; prev_line <= in on every bit_en edge, in any state.
REQ-013 SHALL take no sample and change no state while bit_en = 0; all pulse outputs are 0 on such edges.
REQ-014 SHALL implement two states: HUNT (reset state) and DATA.
REQ-015 HUNT: SHALL shift d into 8-bit sync_sh (reset 8'hFF), newest at LSB; no out_valid.
REQ-016 HUNT: when the shifted value equals 8'b0000_0001, SHALL pulse sync_found, go to DATA, set ones_cnt = 1, clear bit_cnt.
REQ-017 DATA: SHALL count consecutive decoded 1s in ones_cnt (0..6); a decoded 0 clears it.
REQ-018 DATA, ones_cnt < 6: SHALL output d on out with out_valid = 1.
REQ-019 DATA, ones_cnt == 6, d = 0: SHALL drop the bit as stuffed (out_valid = 0) and clear ones_cnt.
REQ-020 DATA, ones_cnt == 6, d = 1: SHALL pulse stuff_err, go to HUNT, set sync_sh to 8'hFF, discard the partial byte, and emit no out_valid.
REQ-021 DATA SHALL exit only by REQ-020 or reset.
REQ-022 SHALL assemble data bits LSB-first into a shift register with a 3-bit bit_cnt; the 8th valid bit updates byte_out and pulses byte_valid in the same cycle as that bit's out_valid, and bit_cnt wraps to 0.
REQ-023 byte_out SHALL hold its value between byte_valid pulses.

Reset
REQ-024 Reset SHALL set state = HUNT, prev_line = 1, sync_sh = 8'hFF, ones_cnt = 0, bit_cnt = 0.
REQ-025 Reset SHALL clear out, out_valid, sync_found, stuff_err, byte_valid, and byte_out (8'h00).
REQ-026 Reset mid-frame SHALL abort the frame with no pulse; the decoder resumes hunting on the first bit_en after release.

Configuration
REQ-027 With macro NRZI_RX_BYTE_EN defined, SHALL include the byte assembler of REQ-022/023.
REQ-028 Without NRZI_RX_BYTE_EN, SHALL omit the byte assembler, tie byte_out to 8'h00 and byte_valid to 0, and leave all other behaviour unchanged.

Verification
REQ-029 Reset: assert reset mid-DATA without a clock edge -> all outputs 0 immediately; next sync is required before any out_valid.
REQ-030 Sync: line 0,1,0,1,0,1,0,0 (bit_en = 1) -> sync_found pulses once after the 8th sample; out_valid stays 0 throughout.
REQ-031 Byte (BYTE_EN defined): after sync, send decoded 1,0,1,0,0,1,0,1 -> 8 out_valid pulses; byte_valid with byte_out = 8'hA5 on the 8th.
REQ-032 Unstuff: after sync, send decoded 1,1,1,1,1,0 -> 5 out_valid pulses with out = 1; the 0 is dropped; ones_cnt = 0.
REQ-033 Abort: after sync, send decoded 1,1,1,1,1,1 -> 5 out_valid pulses, then stuff_err pulse, no byte_valid, state HUNT.
REQ-034 Gaps: repeat REQ-031 with bit_en low for 3 cycles between each bit -> identical output sequence; no pulse occurs in gap cycles.
